// File: rtl/burst_matrix_buffer.sv
// Burst-accessed store of NUM_MATRICES square signed matrices with a LANES-wide beat interface
// plus a combinational random-access element read port.
module burst_matrix_buffer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MATRIX_DIM   = 3,
    parameter int unsigned NUM_MATRICES = 2,
    parameter int unsigned LANES        = 2,
    localparam int unsigned E  = MATRIX_DIM * MATRIX_DIM,
    localparam int unsigned MW = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1,
    localparam int unsigned AW = (E > 1) ? $clog2(E) : 1
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic                        cmd_valid_in,
    output logic                        cmd_ready_out,
    input  logic                        cmd_write_in,
    input  logic                        cmd_all_in,
    input  logic [MW-1:0]               cmd_matrix_in,
    input  logic                        wr_valid_in,
    input  logic [LANES*DATA_WIDTH-1:0] wr_data_in,
    output logic                        rd_valid_out,
    input  logic                        rd_ready_in,
    output logic [LANES*DATA_WIDTH-1:0] rd_data_out,
    input  logic                        abort_in,
    output logic                        done_out,
    input  logic [MW-1:0]               elem_matrix_in,
    input  logic [AW-1:0]               elem_addr_in,
    output logic [DATA_WIDTH-1:0]       elem_data_out
);

    localparam int unsigned B  = (E + LANES - 1) / LANES;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;

    logic [DATA_WIDTH-1:0]       r_mem [NUM_MATRICES*E];
    logic [1:0]                  r_state;
    logic [BW-1:0]               r_beat;
    logic [MW-1:0]               r_matrix;
    logic                        r_all;
    logic                        r_rd_valid;
    logic                        r_done;
    logic [LANES*DATA_WIDTH-1:0] r_rd_data;

    logic                        w_idle;
    logic                        w_accept;
    logic                        w_bad_cmd;
    logic                        w_last_beat;
    logic                        w_final;
    logic                        w_wr_fire;
    logic [BW-1:0]               w_next_beat;
    logic [MW-1:0]               w_next_matrix;
    logic [BW-1:0]               w_ld_beat;
    logic [MW-1:0]               w_ld_matrix;
    logic [LANES*DATA_WIDTH-1:0] w_ld_data;

    assign w_idle        = (r_state == StIdle);
    assign w_accept      = cmd_valid_in && w_idle;
    assign w_bad_cmd     = !cmd_all_in && (32'(cmd_matrix_in) >= NUM_MATRICES);
    assign w_last_beat   = (r_beat == BW'(B - 1));
    assign w_final       = w_last_beat && (!r_all || (r_matrix == MW'(NUM_MATRICES - 1)));
    assign w_wr_fire     = (r_state == StWrite) && wr_valid_in && !abort_in;
    assign w_next_beat   = w_last_beat ? '0 : r_beat + 1'b1;
    assign w_next_matrix = w_last_beat ? r_matrix + 1'b1 : r_matrix;

    // Beat to load into the read register: first beat on acceptance, else the following beat.
    assign w_ld_beat   = w_idle ? '0 : w_next_beat;
    assign w_ld_matrix = w_idle ? (cmd_all_in ? '0 : cmd_matrix_in) : w_next_matrix;

    always_comb begin
        w_ld_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if ((32'(w_ld_beat) * LANES + k < E) && (32'(w_ld_matrix) < NUM_MATRICES)) begin
                w_ld_data[k*DATA_WIDTH +: DATA_WIDTH] =
                    r_mem[32'(w_ld_matrix) * E + 32'(w_ld_beat) * LANES + k];
            end
        end
    end

    always_comb begin
        elem_data_out = '0;
        if ((32'(elem_matrix_in) < NUM_MATRICES) && (32'(elem_addr_in) < E)) begin
            elem_data_out = r_mem[32'(elem_matrix_in) * E + 32'(elem_addr_in)];
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned i = 0; i < NUM_MATRICES * E; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            // Lanes past the last element of the final beat are dropped.
            for (int unsigned k = 0; k < LANES; k++) begin
                if (32'(r_beat) * LANES + k < E) begin
                    r_mem[32'(r_matrix) * E + 32'(r_beat) * LANES + k] <=
                        wr_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_matrix   <= '0;
            r_all      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_beat   <= '0;
                        r_all    <= cmd_all_in;
                        r_matrix <= w_ld_matrix;
                        if (w_bad_cmd) begin
                            r_done <= 1'b1;
                        end else if (cmd_write_in) begin
                            r_state <= StWrite;
                        end else begin
                            r_state    <= StRead;
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= w_ld_data;
                        end
                    end
                end
                StWrite: begin
                    if (abort_in) begin
                        r_state <= StIdle;
                    end else if (wr_valid_in) begin
                        if (w_final) begin
                            r_state <= StIdle;
                            r_beat  <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat   <= w_next_beat;
                            r_matrix <= w_next_matrix;
                        end
                    end
                end
                StRead: begin
                    if (abort_in) begin
                        r_state    <= StIdle;
                        r_rd_valid <= 1'b0;
                    end else if (r_rd_valid && rd_ready_in) begin
                        if (w_final) begin
                            r_state    <= StIdle;
                            r_rd_valid <= 1'b0;
                            r_beat     <= '0;
                            r_done     <= 1'b1;
                        end else begin
                            r_beat    <= w_next_beat;
                            r_matrix  <= w_next_matrix;
                            r_rd_data <= w_ld_data;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cmd_ready_out = w_idle;
    assign rd_valid_out  = r_rd_valid;
    assign rd_data_out   = r_rd_data;
    assign done_out      = r_done;

endmodule

// File: tb/tb_burst_matrix_buffer.sv
// Directed bench for burst_matrix_buffer at default parameters (3x3 matrices, 2 lanes, 5 beats).
module tb_burst_matrix_buffer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_all;
    logic [0:0]  cmd_matrix;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        abort;
    logic        done;
    logic [0:0]  elem_matrix;
    logic [3:0]  elem_addr;
    logic [7:0]  elem_data;

    int checks = 0;
    int errors = 0;
    int valid_cycles;

    burst_matrix_buffer dut (
        .clock_in      (clk),
        .reset_n_in    (rst_n),
        .cmd_valid_in  (cmd_valid),
        .cmd_ready_out (cmd_ready),
        .cmd_write_in  (cmd_write),
        .cmd_all_in    (cmd_all),
        .cmd_matrix_in (cmd_matrix),
        .wr_valid_in   (wr_valid),
        .wr_data_in    (wr_data),
        .rd_valid_out  (rd_valid),
        .rd_ready_in   (rd_ready),
        .rd_data_out   (rd_data),
        .abort_in      (abort),
        .done_out      (done),
        .elem_matrix_in(elem_matrix),
        .elem_addr_in  (elem_addr),
        .elem_data_out (elem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_elem(input logic m, input int a, input logic [7:0] exp);
        elem_matrix = m;
        elem_addr   = 4'(a);
        #1;
        check_eq($sformatf("elem m%0d a%0d", m, a), 32'(elem_data), 32'(exp));
    endtask

    task automatic issue(input logic wr, input logic all, input logic m);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_all    = all;
        cmd_matrix = m;
        tick();
        cmd_valid  = 1'b0;
        // Later changes must not affect the accepted burst.
        cmd_write  = ~wr;
        cmd_matrix = ~m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_all = 1'b0; cmd_matrix = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; abort = 1'b0;
        elem_matrix = '0; elem_addr = '0;
        #1;
        check_eq("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // Single write of matrix 1; lane 1 of the last beat (99) is dropped.
        issue(1'b1, 1'b0, 1'b1);
        check_eq("wr busy cmd_ready", 32'(cmd_ready), 32'd0);
        wr_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            wr_data = (b == 4) ? {8'd99, 8'd9} : {8'(2 * b + 2), 8'(2 * b + 1)};
            tick();
            if (b < 4) check_eq("wr no early done", 32'(done), 32'd0);
        end
        wr_valid = 1'b0;
        check_eq("wr done", 32'(done), 32'd1);
        check_eq("wr done cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check_eq("wr done one cycle", 32'(done), 32'd0);
        for (int a = 0; a < 9; a++) check_elem(1'b1, a, 8'(a + 1));
        check_elem(1'b0, 0, 8'd0);
        tick();

        // Read matrix 1 with consumer always ready.
        rd_ready = 1'b1;
        issue(1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) begin
            check_eq($sformatf("rd valid b%0d", b), 32'(rd_valid), 32'd1);
            check_eq($sformatf("rd data b%0d", b), 32'(rd_data),
                     (b == 4) ? 32'h0009 : 32'({8'(2 * b + 2), 8'(2 * b + 1)}));
            tick();
        end
        check_eq("rd end valid", 32'(rd_valid), 32'd0);
        check_eq("rd done", 32'(done), 32'd1);
        check_eq("rd cmd_ready", 32'(cmd_ready), 32'd1);
        tick();

        // Read with three stalled cycles on beat 2.
        valid_cycles = 0;
        issue(1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 10; s++) begin
            if (rd_valid) valid_cycles++;
            if (s == 2) rd_ready = 1'b0;
            if (s >= 2 && s <= 5) check_eq($sformatf("stall data s%0d", s), 32'(rd_data), 32'h0605);
            if (s == 5) rd_ready = 1'b1;
            if (!rd_valid && s > 0) begin
                check_eq("stall done", 32'(done), 32'd1);
                break;
            end
            tick();
        end
        check_eq("stall beat cycles", 32'(valid_cycles), 32'd8);
        tick();

        // All-matrices write of values 1..20 in 10 beats.
        issue(1'b1, 1'b1, 1'b0);
        wr_valid = 1'b1;
        for (int b = 0; b < 10; b++) begin
            wr_data = {8'(2 * b + 2), 8'(2 * b + 1)};
            tick();
            if (b == 4) check_eq("all no mid done", 32'(done), 32'd0);
        end
        wr_valid = 1'b0;
        check_eq("all done", 32'(done), 32'd1);
        for (int a = 0; a < 9; a++) check_elem(1'b0, a, 8'(a + 1));
        for (int a = 0; a < 9; a++) check_elem(1'b1, a, 8'(a + 11));
        tick();

        // Abort coincident with beat 2 of a write to matrix 0.
        issue(1'b1, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data = 16'h2120; tick();
        wr_data = 16'h2322; tick();
        wr_data = 16'h2524; abort = 1'b1; tick();
        abort = 1'b0; wr_valid = 1'b0;
        check_eq("abort idle", 32'(cmd_ready), 32'd1);
        check_eq("abort no done", 32'(done), 32'd0);
        tick();
        check_eq("abort no done later", 32'(done), 32'd0);
        for (int a = 0; a < 4; a++) check_elem(1'b0, a, 8'(8'h20 + a));
        for (int a = 4; a < 9; a++) check_elem(1'b0, a, 8'(a + 1));
        tick();

        // Asynchronous reset in the middle of a read.
        rd_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b1);
        check_eq("pre-rst rd data", 32'(rd_data), 32'h0c0b);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("async rst rd_valid", 32'(rd_valid), 32'd0);
        check_eq("async rst rd_data", 32'(rd_data), 32'd0);
        check_eq("async rst cmd_ready", 32'(cmd_ready), 32'd1);
        for (int a = 0; a < 9; a++) begin
            check_elem(1'b0, a, 8'd0);
            check_elem(1'b1, a, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post-rst done", 32'(done), 32'd0);
        check_eq("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
